// File: rtl/sdram_responder_if.sv
// sdram_responder_if: SDRAM command, address and byte-mask pins between controller and device.
// Ports: SD_P_BA bank, SD_P_ADR address, SD_P_nRAS/nCAS/nWE/nCS command strobes,
//        SD_P_CKE clock enable, SD_P_DQM write byte mask. DQ stays a plain inout on the device.
interface sdram_responder_if;
    logic [1:0]  SD_P_BA;
    logic [12:0] SD_P_ADR;
    logic        SD_P_nRAS;
    logic        SD_P_nCAS;
    logic        SD_P_nWE;
    logic        SD_P_nCS;
    logic        SD_P_CKE;
    logic [1:0]  SD_P_DQM;
    modport master (output SD_P_BA, SD_P_ADR, SD_P_nRAS, SD_P_nCAS, SD_P_nWE, SD_P_nCS, SD_P_CKE, SD_P_DQM);
    modport slave  (input  SD_P_BA, SD_P_ADR, SD_P_nRAS, SD_P_nCAS, SD_P_nWE, SD_P_nCS, SD_P_CKE, SD_P_DQM);
endinterface

// File: rtl/sdram_responder.sv
// sdram_responder: SDRAM device stand-in answering the controller's pin interface.
// Ports: CLK clock, nRST async active-low reset, SD_P_DATA bidirectional DQ,
//        sd command/address/mask pins, mode_set/cas_lat mode register state,
//        ref_count accepted refreshes (saturating), err_flags sticky protocol errors.
module sdram_responder #(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 6,
    parameter int CAS_DEF  = 3,
    parameter int TRCD     = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    inout  wire  [15:0]      SD_P_DATA,
    sdram_responder_if.slave sd,
    output logic             mode_set,
    output logic [1:0]       cas_lat,
    output logic [15:0]      ref_count,
    output logic [5:0]       err_flags
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

    logic [3:0]          cmd;
    logic                is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
    logic [1:0]          ba;
    logic [12:0]         adr;
    logic [AW-1:0]       idx;
    logic                wr_en;
    logic [15:0]         mem [2**AW];

    logic [3:0]          active_q, active_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] row_d [4];
    logic [TW-1:0]       trcd_q [4];
    logic [TW-1:0]       trcd_d [4];
    logic                mode_set_q, mode_set_d;
    logic [1:0]          cas_lat_q, cas_lat_d;
    logic [15:0]         ref_q, ref_d;
    logic [5:0]          err_q, err_d;
    logic [1:0]          pv_q, pv_d;
    logic [15:0]         pd_q [2];
    logic [15:0]         pd_d [2];
    logic                oe_q, oe_d;
    logic [15:0]         dout_q, dout_d;

    assign ba     = sd.SD_P_BA;
    assign adr    = sd.SD_P_ADR;
    assign cmd    = {sd.SD_P_nCS, sd.SD_P_nRAS, sd.SD_P_nCAS, sd.SD_P_nWE};
    assign is_act = sd.SD_P_CKE && cmd == 4'b0011;
    assign is_rd  = sd.SD_P_CKE && cmd == 4'b0101;
    assign is_wr  = sd.SD_P_CKE && cmd == 4'b0100;
    assign is_pre = sd.SD_P_CKE && cmd == 4'b0010;
    assign is_ref = sd.SD_P_CKE && cmd == 4'b0001;
    assign is_mrs = sd.SD_P_CKE && cmd == 4'b0000;
    assign idx    = {ba, row_q[ba], adr[COL_BITS-1:0]};

    // Read return pipeline: slot 0 feeds the DQ register on the next edge, so a
    // read with latency CL enters slot CL-2 and is driven from edge E+CL-1.
    always_comb begin
        active_d   = active_q;
        row_d      = row_q;
        mode_set_d = mode_set_q;
        cas_lat_d  = cas_lat_q;
        ref_d      = ref_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        for (int b = 0; b < 4; b++) trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - TW'(1) : '0;
        pv_d       = {1'b0, pv_q[1]};
        pd_d[0]    = pd_q[1];
        pd_d[1]    = '0;
        oe_d       = pv_q[0];
        dout_d     = pd_q[0];
        if (is_act) begin
            err_d[1]     = err_q[1] | active_q[ba];
            active_d[ba] = 1'b1;
            row_d[ba]    = adr[ROW_BITS-1:0];
            trcd_d[ba]   = TW'(TRCD - 1);
        end
        if (is_wr) err_d[5] = err_q[5] | oe_q;
        if (is_rd || is_wr) begin
            if (!active_q[ba]) begin
                err_d[0] = 1'b1;
            end else begin
                err_d[2] = err_q[2] | (trcd_q[ba] != '0);
                wr_en    = is_wr;
                if (adr[10]) active_d[ba] = 1'b0;
                if (is_rd) begin
                    pv_d[cas_lat_q[0]] = 1'b1;
                    pd_d[cas_lat_q[0]] = mem[idx];
                end
            end
        end
        if (is_pre) begin
            if (adr[10]) active_d = '0;
            else active_d[ba] = 1'b0;
        end
        if (is_ref) begin
            err_d[3] = err_q[3] | (|active_q);
            ref_d    = (ref_q == 16'hFFFF) ? ref_q : ref_q + 16'd1;
        end
        if (is_mrs) begin
            err_d[3] = err_q[3] | (|active_q);
            if (adr[6:5] == 2'b01) begin
                cas_lat_d  = adr[5:4];
                mode_set_d = 1'b1;
            end else begin
                err_d[4] = 1'b1;
            end
            if (adr[2:0] != 3'd0) err_d[4] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            active_q   <= '0;
            row_q      <= '{default: '0};
            trcd_q     <= '{default: '0};
            mode_set_q <= 1'b0;
            cas_lat_q  <= 2'(CAS_DEF);
            ref_q      <= '0;
            err_q      <= '0;
            pv_q       <= '0;
            pd_q       <= '{default: '0};
            oe_q       <= 1'b0;
            dout_q     <= '0;
        end else begin
            active_q   <= active_d;
            row_q      <= row_d;
            trcd_q     <= trcd_d;
            mode_set_q <= mode_set_d;
            cas_lat_q  <= cas_lat_d;
            ref_q      <= ref_d;
            err_q      <= err_d;
            pv_q       <= pv_d;
            pd_q       <= pd_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
        end
    end

    // Storage is deliberately left unreset, like a real DRAM array.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            if (!sd.SD_P_DQM[0]) mem[idx][7:0] <= SD_P_DATA[7:0];
            if (!sd.SD_P_DQM[1]) mem[idx][15:8] <= SD_P_DATA[15:8];
        end
    end

    assign SD_P_DATA = oe_q ? dout_q : 'z;
    assign mode_set  = mode_set_q;
    assign cas_lat   = cas_lat_q;
    assign ref_count = ref_q;
    assign err_flags = err_q;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed and randomized checks of sdram_responder against a cycle-indexed reference model.
module tb_sdram_responder;
    localparam int TRCD = 2;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100,
                           C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = '0;
    wire  [15:0] dq;
    logic        mode_set;
    logic [1:0]  cas_lat;
    logic [15:0] ref_count;
    logic [5:0]  err_flags;

    always #5 clk = ~clk;

    sdram_responder_if sd();
    assign dq = tb_oe ? tb_dq : 'z;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (dq[g]);
    end

    sdram_responder #(.ROW_BITS(2), .COL_BITS(6), .CAS_DEF(3), .TRCD(TRCD)) dut (
        .CLK(clk), .nRST(nrst), .SD_P_DATA(dq), .sd(sd),
        .mode_set(mode_set), .cas_lat(cas_lat), .ref_count(ref_count), .err_flags(err_flags)
    );

    // Reference model: cycle numbers, per-byte validity and a map of cycles at which read data must be on DQ.
    logic [15:0] m_mem [1024];
    logic [1:0]  m_val [1024];
    bit          m_open [4];
    int          m_row [4];
    int          m_act [4];
    int          m_cl, m_ref, cyc, last_due, checks, errors;
    bit          m_mode;
    logic [5:0]  m_err;
    logic [15:0] exp_d [int];
    logic [15:0] exp_m [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic reset_model();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 0;
            m_row[b]  = 0;
            m_act[b]  = -100;
        end
        for (int i = 0; i < 1024; i++) m_val[i] = 2'b00;
        m_cl = 3; m_ref = 0; m_mode = 0; m_err = '0; last_due = 0;
        exp_d.delete();
        exp_m.delete();
    endtask

    task automatic model(input logic [3:0] c, input int b, input logic [12:0] a, input logic [15:0] d, input logic [1:0] m);
        int  idx;
        bit  any;
        any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        idx = b * 256 + (m_row[b] % 4) * 64 + int'(a) % 64;
        case (c)
            C_ACT: begin
                if (m_open[b]) m_err[1] = 1'b1;
                m_open[b] = 1; m_row[b] = int'(a); m_act[b] = cyc;
            end
            C_RD, C_WR: begin
                if (!m_open[b]) begin
                    m_err[0] = 1'b1;
                end else begin
                    if (cyc - m_act[b] < TRCD) m_err[2] = 1'b1;
                    if (c == C_WR) begin
                        if (!m[0]) begin m_mem[idx][7:0] = d[7:0]; m_val[idx][0] = 1'b1; end
                        if (!m[1]) begin m_mem[idx][15:8] = d[15:8]; m_val[idx][1] = 1'b1; end
                    end else begin
                        exp_d[cyc + m_cl - 1] = m_mem[idx];
                        exp_m[cyc + m_cl - 1] = {{8{m_val[idx][1]}}, {8{m_val[idx][0]}}};
                        last_due = cyc + m_cl;
                    end
                    if (a[10]) m_open[b] = 0;
                end
            end
            C_PRE: begin
                if (a[10]) for (int k = 0; k < 4; k++) m_open[k] = 0;
                else m_open[b] = 0;
            end
            C_REF: begin
                if (any) m_err[3] = 1'b1;
                if (m_ref < 65535) m_ref++;
            end
            C_MRS: begin
                if (any) m_err[3] = 1'b1;
                if (a[6:4] == 3'd2 || a[6:4] == 3'd3) begin
                    m_cl = int'(a[6:4]); m_mode = 1;
                end else begin
                    m_err[4] = 1'b1;
                end
                if (a[2:0] != 3'd0) m_err[4] = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic set_cmd(input logic [3:0] c);
        {sd.SD_P_nCS, sd.SD_P_nRAS, sd.SD_P_nCAS, sd.SD_P_nWE} = c;
    endtask

    // One command per cycle: drive after the falling edge, sample at the rising edge, check DQ at the next falling edge.
    task automatic cmd(input logic [3:0] c, input int b, input logic [12:0] a, input logic [15:0] d, input logic [1:0] m);
        set_cmd(c);
        sd.SD_P_BA = 2'(b); sd.SD_P_ADR = a; sd.SD_P_DQM = m;
        tb_dq = d; tb_oe = (c == C_WR);
        @(posedge clk);
        cyc++;
        if (sd.SD_P_CKE) model(c, b, a, d, m);
        #1;
        set_cmd(C_NOP);
        tb_oe = 1'b0;
        @(negedge clk);
        if (exp_d.exists(cyc)) begin
            if (exp_m[cyc] != 16'h0) chk("rd_data", dq & exp_m[cyc], exp_d[cyc] & exp_m[cyc]);
            exp_d.delete(cyc);
            exp_m.delete(cyc);
        end else begin
            chk("dq_hiz", dq, 16'hFFFF);
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cmd(C_NOP, 0, 13'h0, 16'h0, 2'b00);
    endtask

    task automatic chk_status();
        chk("mode_set", 32'(mode_set), 32'(m_mode));
        chk("cas_lat", 32'(cas_lat), 32'(m_cl));
        chk("ref_count", 32'(ref_count), 32'(m_ref));
        chk("err_flags", 32'(err_flags), 32'(m_err));
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        set_cmd(C_NOP);
        sd.SD_P_BA = '0; sd.SD_P_ADR = '0; sd.SD_P_DQM = '0; sd.SD_P_CKE = 1'b1;
        reset_model();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        nop(1);
        chk_status();

        cmd(C_PRE, 0, 13'h400, 16'h0, 2'b00);
        for (int i = 0; i < 8; i++) cmd(C_REF, 0, 13'h0, 16'h0, 2'b00);
        cmd(C_MRS, 0, 13'h030, 16'h0, 2'b00);
        nop(1);
        chk_status();

        cmd(C_ACT, 1, 13'd5, 16'h0, 2'b00);
        nop(1);
        cmd(C_WR, 1, 13'h012, 16'hA5C3, 2'b00);
        cmd(C_RD, 1, 13'h012, 16'h0, 2'b00);
        nop(4);
        cmd(C_WR, 1, 13'h020, 16'h1234, 2'b00);
        cmd(C_WR, 1, 13'h020, 16'hFFFF, 2'b10);
        cmd(C_RD, 1, 13'h020, 16'h0, 2'b00);
        nop(4);

        cmd(C_PRE, 0, 13'h400, 16'h0, 2'b00);
        cmd(C_MRS, 0, 13'h020, 16'h0, 2'b00);
        cmd(C_ACT, 2, 13'd3, 16'h0, 2'b00);
        nop(1);
        cmd(C_WR, 2, 13'h001, 16'h0BAD, 2'b00);
        cmd(C_WR, 2, 13'h002, 16'hC0DE, 2'b00);
        cmd(C_RD, 2, 13'h001, 16'h0, 2'b00);
        cmd(C_RD, 2, 13'h002, 16'h0, 2'b00);
        nop(3);
        chk_status();

        sd.SD_P_CKE = 1'b0;
        cmd(C_REF, 0, 13'h0, 16'h0, 2'b00);
        sd.SD_P_CKE = 1'b1;
        chk_status();

        cmd(C_PRE, 0, 13'h400, 16'h0, 2'b00);
        cmd(C_MRS, 0, ($urandom_range(0, 1) != 0) ? 13'h020 : 13'h030, 16'h0, 2'b00);
        for (int i = 0; i < 400; i++) begin
            int b, op, nxt;
            logic [12:0] a;
            b = $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            nxt = cyc + 1;
            a = {2'b00, (op == 0), 4'b0000, 6'($urandom_range(0, 7))};
            if (!m_open[b]) cmd(C_ACT, b, 13'($urandom_range(0, 8191)), 16'h0, 2'b00);
            else if (nxt - m_act[b] < TRCD) cmd(C_NOP, 0, 13'h0, 16'h0, 2'b00);
            else if (op < 4) cmd(C_RD, b, a, 16'h0, 2'b00);
            else if (op < 8 && nxt > last_due) cmd(C_WR, b, a, 16'($urandom), 2'($urandom_range(0, 3)));
            else if (op == 8) cmd(C_PRE, b, 13'h0, 16'h0, 2'b00);
            else cmd(C_NOP, 0, 13'h0, 16'h0, 2'b00);
        end
        nop(4);
        chk_status();

        cmd(C_PRE, 0, 13'h400, 16'h0, 2'b00);
        nop(2);
        cmd(C_RD, 0, 13'h003, 16'h0, 2'b00);
        nop(1);
        chk_status();
        cmd(C_ACT, 0, 13'd1, 16'h0, 2'b00);
        cmd(C_RD, 0, 13'h000, 16'h0, 2'b00);
        nop(4);
        chk_status();
        cmd(C_REF, 0, 13'h0, 16'h0, 2'b00);
        chk_status();
        cmd(C_MRS, 0, 13'h050, 16'h0, 2'b00);
        chk_status();

        cmd(C_WR, 0, 13'h005, 16'h5A5A, 2'b00);
        cmd(C_RD, 0, 13'h005, 16'h0, 2'b00);
        nop(m_cl - 1);
        nrst = 1'b0;
        #1;
        chk("rst_dq_hiz", dq, 16'hFFFF);
        chk("rst_err", 32'(err_flags), 32'h0);
        reset_model();
        @(negedge clk);
        nrst = 1'b1;
        nop(3);
        chk_status();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
